// File: rtl/pipe_exe_mem_reg_if.sv
// EXE->MEM boundary bundle: EXE-side inputs, registered MEM-side copies and
// the CP0 exception handshake.
interface pipe_exe_mem_reg_if #(
  parameter int unsigned DATA_W = 32
);
  logic              ex_valid;
  logic [DATA_W-1:0] ex_pc;
  logic              ex_bd;
  logic [DATA_W-1:0] ex_r;
  logic              ex_v;
  logic              ex_ovr_en;
  logic [DATA_W-1:0] ex_b;
  logic [4:0]        ex_rn;
  logic              ex_wreg;
  logic              ex_m2reg;
  logic              ex_wmem;
  logic              mem_stall;
  logic              flush;
  logic              exc_ack;

  logic              mm_valid;
  logic [DATA_W-1:0] mm_pc;
  logic              mm_bd;
  logic [DATA_W-1:0] mm_r;
  logic [DATA_W-1:0] mm_b;
  logic [4:0]        mm_rn;
  logic              mm_wreg;
  logic              mm_m2reg;
  logic              mm_wmem;
  logic              ex_hold;
  logic              exc_req;
  logic [DATA_W-1:0] exc_epc;
  logic [4:0]        exc_cause;
  logic              exc_bd;

  modport master (
    output ex_valid, ex_pc, ex_bd, ex_r, ex_v, ex_ovr_en, ex_b, ex_rn,
           ex_wreg, ex_m2reg, ex_wmem, mem_stall, flush, exc_ack,
    input  mm_valid, mm_pc, mm_bd, mm_r, mm_b, mm_rn, mm_wreg, mm_m2reg,
           mm_wmem, ex_hold, exc_req, exc_epc, exc_cause, exc_bd
  );

  modport slave (
    input  ex_valid, ex_pc, ex_bd, ex_r, ex_v, ex_ovr_en, ex_b, ex_rn,
           ex_wreg, ex_m2reg, ex_wmem, mem_stall, flush, exc_ack,
    output mm_valid, mm_pc, mm_bd, mm_r, mm_b, mm_rn, mm_wreg, mm_m2reg,
           mm_wmem, ex_hold, exc_req, exc_epc, exc_cause, exc_bd
  );
endinterface

// File: rtl/pipe_exe_mem_reg.sv
// EXE->MEM pipeline register; converts a trapping ALU overflow into a held
// CP0 exception request and squashes the faulting instruction.
module pipe_exe_mem_reg #(
  parameter int unsigned DATA_W   = 32,
  parameter logic [4:0]  CAUSE_OV = 5'd12
) (
  input logic                clk,
  input logic                rst,
  pipe_exe_mem_reg_if.slave  bus
);

  typedef enum logic [1:0] {RUN, TRAP, DRAIN} state_t;

  state_t state, state_nxt;
  logic   trap;
  logic   load;
  logic   pass;

  always_comb begin
    state_nxt   = state;
    trap        = 1'b0;
    bus.ex_hold = 1'b1;
    case (state)
      RUN: begin
        bus.ex_hold = 1'b0;
        trap = bus.ex_valid & bus.ex_v & bus.ex_ovr_en & ~bus.flush & ~bus.mem_stall;
        if (trap) state_nxt = TRAP;
      end
      TRAP:    if (bus.exc_ack) state_nxt = DRAIN;
      DRAIN:   state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  // Outside RUN the slot always loads a bubble; data fields only move on a real pass.
  assign load = ~((state == RUN) & bus.mem_stall);
  assign pass = (state == RUN) & ~bus.mem_stall & ~bus.flush & ~trap;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= RUN;
      bus.mm_valid  <= 1'b0;
      bus.mm_pc     <= '0;
      bus.mm_bd     <= 1'b0;
      bus.mm_r      <= '0;
      bus.mm_b      <= '0;
      bus.mm_rn     <= '0;
      bus.mm_wreg   <= 1'b0;
      bus.mm_m2reg  <= 1'b0;
      bus.mm_wmem   <= 1'b0;
      bus.exc_req   <= 1'b0;
      bus.exc_epc   <= '0;
      bus.exc_cause <= '0;
      bus.exc_bd    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (load) begin
        bus.mm_valid <= pass & bus.ex_valid;
        bus.mm_wreg  <= pass & bus.ex_valid & bus.ex_wreg;
        bus.mm_m2reg <= pass & bus.ex_valid & bus.ex_m2reg;
        bus.mm_wmem  <= pass & bus.ex_valid & bus.ex_wmem;
      end
      if (pass) begin
        bus.mm_pc <= bus.ex_pc;
        bus.mm_bd <= bus.ex_bd;
        bus.mm_r  <= bus.ex_r;
        bus.mm_b  <= bus.ex_b;
        bus.mm_rn <= bus.ex_rn;
      end
      if (trap) begin
        bus.exc_req   <= 1'b1;
        bus.exc_epc   <= bus.ex_bd ? bus.ex_pc - DATA_W'(4) : bus.ex_pc;
        bus.exc_bd    <= bus.ex_bd;
        bus.exc_cause <= CAUSE_OV;
      end else if ((state == TRAP) && bus.exc_ack) begin
        bus.exc_req   <= 1'b0;
        bus.exc_cause <= '0;
      end
    end
  end

endmodule

// File: tb/tb_pipe_exe_mem_reg.sv
// Bench for pipe_exe_mem_reg: directed scenarios plus randomized traffic
// compared against a rule-level model of the stage.
module tb_pipe_exe_mem_reg;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  pipe_exe_mem_reg_if #(.DATA_W(32)) bus ();

  pipe_exe_mem_reg #(.DATA_W(32), .CAUSE_OV(5'd12)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Reference model: pending-exception / drain-cycle flags plus expected outputs
  logic        m_pend, m_drain;
  logic        m_valid, m_bd, m_wreg, m_m2reg, m_wmem, m_req, m_ebd;
  logic [31:0] m_pc, m_r, m_b, m_epc;
  logic [4:0]  m_rn, m_cause;

  task automatic model_reset();
    m_pend = 0; m_drain = 0;
    m_valid = 0; m_bd = 0; m_wreg = 0; m_m2reg = 0; m_wmem = 0;
    m_req = 0; m_ebd = 0; m_pc = 0; m_r = 0; m_b = 0; m_epc = 0;
    m_rn = 0; m_cause = 0;
  endtask

  task automatic set_idle();
    bus.ex_valid = 0; bus.ex_pc = 0; bus.ex_bd = 0; bus.ex_r = 0; bus.ex_v = 0;
    bus.ex_ovr_en = 0; bus.ex_b = 0; bus.ex_rn = 0; bus.ex_wreg = 0;
    bus.ex_m2reg = 0; bus.ex_wmem = 0; bus.mem_stall = 0; bus.flush = 0;
    bus.exc_ack = 0;
  endtask

  // Apply the stage's rules to the current inputs, clock once, then commit.
  task automatic tick();
    logic kill_ctrl, take;
    logic n_pend, n_drain, n_req;
    logic [31:0] n_epc;
    logic [4:0] n_cause;
    logic n_ebd;
    kill_ctrl = 0; take = 0;
    n_pend = m_pend; n_drain = m_drain; n_req = m_req;
    n_epc = m_epc; n_cause = m_cause; n_ebd = m_ebd;
    if (m_pend) begin
      kill_ctrl = 1;
      if (bus.exc_ack) begin
        n_req = 0; n_cause = 0; n_pend = 0; n_drain = 1;
      end
    end else if (m_drain) begin
      kill_ctrl = 1; n_drain = 0;
    end else if (!bus.mem_stall) begin
      if (bus.flush) kill_ctrl = 1;
      else if (bus.ex_valid && bus.ex_v && bus.ex_ovr_en) begin
        kill_ctrl = 1; n_req = 1; n_pend = 1; n_cause = 12; n_ebd = bus.ex_bd;
        n_epc = bus.ex_bd ? bus.ex_pc - 32'd4 : bus.ex_pc;
      end else take = 1;
    end
    @(posedge clk);
    #1;
    if (kill_ctrl) begin
      m_valid = 0; m_wreg = 0; m_m2reg = 0; m_wmem = 0;
    end
    if (take) begin
      m_valid = bus.ex_valid; m_wreg = bus.ex_valid & bus.ex_wreg;
      m_m2reg = bus.ex_valid & bus.ex_m2reg; m_wmem = bus.ex_valid & bus.ex_wmem;
      m_pc = bus.ex_pc; m_bd = bus.ex_bd; m_r = bus.ex_r; m_b = bus.ex_b; m_rn = bus.ex_rn;
    end
    m_pend = n_pend; m_drain = n_drain; m_req = n_req;
    m_epc = n_epc; m_cause = n_cause; m_ebd = n_ebd;
  endtask

  task automatic ovf_add(input logic [31:0] pc, input logic bd);
    bus.ex_valid = 1; bus.ex_pc = pc; bus.ex_bd = bd; bus.ex_r = 32'h8000_0001;
    bus.ex_v = 1; bus.ex_ovr_en = 1; bus.ex_rn = 5'd9; bus.ex_wreg = 1;
  endtask

  task automatic test_reset();
    set_idle();
    rst = 1;
    model_reset();
    #12;
    checks++;
    if ({bus.mm_valid, bus.mm_wreg, bus.mm_m2reg, bus.mm_wmem, bus.mm_r, bus.mm_b, bus.mm_pc} !== '0) begin
      errors++; $display("FAIL reset_mm: got valid=%b r=%h b=%h pc=%h want all 0",
                         bus.mm_valid, bus.mm_r, bus.mm_b, bus.mm_pc);
    end
    checks++;
    if ({bus.exc_req, bus.exc_epc, bus.exc_cause, bus.exc_bd, bus.ex_hold} !== '0) begin
      errors++; $display("FAIL reset_exc: got req=%b epc=%h cause=%0d bd=%b hold=%b want 0",
                         bus.exc_req, bus.exc_epc, bus.exc_cause, bus.exc_bd, bus.ex_hold);
    end
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_addu();
    set_idle();
    bus.ex_valid = 1; bus.ex_pc = 32'h0040_0000; bus.ex_r = 32'h8000_0000;
    bus.ex_v = 1; bus.ex_ovr_en = 0; bus.ex_wreg = 1; bus.ex_rn = 5'd3; bus.ex_b = 32'h1234_5678;
    tick();
    checks++;
    if (bus.mm_r !== 32'h8000_0000 || bus.mm_wreg !== 1'b1 || bus.exc_req !== 1'b0) begin
      errors++; $display("FAIL addu: got r=%h wreg=%b req=%b want 80000000 1 0",
                         bus.mm_r, bus.mm_wreg, bus.exc_req);
    end
  endtask

  task automatic test_trap();
    set_idle();
    ovf_add(32'h0040_0010, 1'b0);
    tick();
    checks++;
    if (bus.exc_req !== 1 || bus.exc_epc !== 32'h0040_0010 || bus.exc_cause !== 5'd12 ||
        bus.mm_wreg !== 0 || bus.mm_valid !== 0 || bus.ex_hold !== 1 || bus.exc_bd !== 0) begin
      errors++; $display("FAIL trap_entry: got req=%b epc=%h cause=%0d wreg=%b hold=%b want 1 00400010 12 0 1",
                         bus.exc_req, bus.exc_epc, bus.exc_cause, bus.mm_wreg, bus.ex_hold);
    end
    set_idle();
    bus.ex_valid = 1; bus.ex_wreg = 1; bus.flush = 1;  // ignored while trapped
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (bus.exc_req !== 1 || bus.exc_epc !== 32'h0040_0010 || bus.mm_valid !== 0 || bus.ex_hold !== 1) begin
        errors++; $display("FAIL trap_hold[%0d]: got req=%b epc=%h valid=%b hold=%b want 1 00400010 0 1",
                           i, bus.exc_req, bus.exc_epc, bus.mm_valid, bus.ex_hold);
      end
    end
    set_idle();
    bus.exc_ack = 1;
    tick();
    checks++;
    if (bus.exc_req !== 0 || bus.exc_cause !== 0 || bus.ex_hold !== 1 || bus.mm_valid !== 0) begin
      errors++; $display("FAIL trap_drain: got req=%b cause=%0d hold=%b valid=%b want 0 0 1 0",
                         bus.exc_req, bus.exc_cause, bus.ex_hold, bus.mm_valid);
    end
    bus.exc_ack = 1;  // ack outside TRAP has no effect
    tick();
    checks++;
    if (bus.ex_hold !== 0 || bus.exc_req !== 0) begin
      errors++; $display("FAIL trap_run: got hold=%b req=%b want 0 0", bus.ex_hold, bus.exc_req);
    end
    set_idle();
  endtask

  task automatic test_delay_slot();
    logic [31:0] pcs [2];
    logic [31:0] epcs [2];
    pcs[0] = 32'h0040_0024; epcs[0] = 32'h0040_0020;
    pcs[1] = 32'h0000_0000; epcs[1] = 32'hFFFF_FFFC;
    for (int i = 0; i < 2; i++) begin
      set_idle();
      ovf_add(pcs[i], 1'b1);
      tick();
      checks++;
      if (bus.exc_req !== 1 || bus.exc_epc !== epcs[i] || bus.exc_bd !== 1) begin
        errors++; $display("FAIL delay_slot[%0d]: got req=%b epc=%h bd=%b want 1 %h 1",
                           i, bus.exc_req, bus.exc_epc, bus.exc_bd, epcs[i]);
      end
      set_idle(); bus.exc_ack = 1; tick();
      set_idle(); tick();
    end
  endtask

  task automatic test_flush_trap();
    set_idle();
    ovf_add(32'h0040_0100, 1'b0);
    bus.flush = 1;
    tick();
    checks++;
    if (bus.mm_valid !== 0 || bus.mm_wreg !== 0 || bus.exc_req !== 0 || bus.ex_hold !== 0) begin
      errors++; $display("FAIL flush_trap: got valid=%b wreg=%b req=%b hold=%b want 0 0 0 0",
                         bus.mm_valid, bus.mm_wreg, bus.exc_req, bus.ex_hold);
    end
    set_idle();
    tick();
    checks++;
    if (bus.exc_req !== 0) begin
      errors++; $display("FAIL flush_trap_after: got req=%b want 0", bus.exc_req);
    end
  endtask

  task automatic test_stall();
    set_idle();
    bus.ex_valid = 1; bus.ex_r = 32'hCAFE_0001; bus.ex_wmem = 1; bus.ex_b = 32'h0BAD_F00D;
    tick();
    ovf_add(32'h0040_0200, 1'b0);
    bus.ex_wmem = 0;
    bus.mem_stall = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus.mm_r !== 32'hCAFE_0001 || bus.mm_wmem !== 1 || bus.mm_b !== 32'h0BAD_F00D ||
          bus.exc_req !== 0) begin
        errors++; $display("FAIL stall_hold[%0d]: got r=%h wmem=%b b=%h req=%b want cafe0001 1 0badf00d 0",
                           i, bus.mm_r, bus.mm_wmem, bus.mm_b, bus.exc_req);
      end
    end
    bus.mem_stall = 0;
    tick();
    checks++;
    if (bus.exc_req !== 1 || bus.exc_epc !== 32'h0040_0200 || bus.mm_valid !== 0) begin
      errors++; $display("FAIL stall_release: got req=%b epc=%h valid=%b want 1 00400200 0",
                         bus.exc_req, bus.exc_epc, bus.mm_valid);
    end
    set_idle(); bus.exc_ack = 1; tick();
    set_idle(); tick();
    checks++;
    if (bus.exc_req !== 0 || bus.ex_hold !== 0) begin
      errors++; $display("FAIL stall_once: got req=%b hold=%b want 0 0", bus.exc_req, bus.ex_hold);
    end
  endtask

  task automatic test_async_reset();
    set_idle();
    bus.ex_valid = 1; bus.ex_r = 32'h7777_0000; bus.ex_wreg = 1;
    tick();
    ovf_add(32'h0040_0300, 1'b0);
    tick();
    set_idle();
    #2;
    rst = 1;
    #1;
    model_reset();
    checks++;
    if (bus.exc_req !== 0 || bus.mm_valid !== 0 || bus.mm_r !== 0 || bus.mm_wreg !== 0 ||
        bus.exc_epc !== 0 || bus.ex_hold !== 0) begin
      errors++; $display("FAIL async_reset: got req=%b valid=%b r=%h epc=%h hold=%b want all 0",
                         bus.exc_req, bus.mm_valid, bus.mm_r, bus.exc_epc, bus.ex_hold);
    end
    #1;
    rst = 0;
    tick();
    checks++;
    if (bus.ex_hold !== 0 || bus.exc_req !== 0) begin
      errors++; $display("FAIL async_reset_run: got hold=%b req=%b want 0 0", bus.ex_hold, bus.exc_req);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      bus.ex_valid  = ($urandom_range(0, 3) != 0);
      bus.ex_pc     = ($urandom_range(0, 15) == 0) ? 32'h0 : ($urandom() & 32'hFFFF_FFFC);
      bus.ex_bd     = $urandom_range(0, 1);
      bus.ex_r      = $urandom();
      bus.ex_v      = $urandom_range(0, 1);
      bus.ex_ovr_en = ($urandom_range(0, 2) == 0);
      bus.ex_b      = $urandom();
      bus.ex_rn     = 5'($urandom_range(0, 31));
      bus.ex_wreg   = $urandom_range(0, 1);
      bus.ex_m2reg  = $urandom_range(0, 1);
      bus.ex_wmem   = $urandom_range(0, 1);
      bus.mem_stall = ($urandom_range(0, 4) == 0);
      bus.flush     = ($urandom_range(0, 7) == 0);
      bus.exc_ack   = ($urandom_range(0, 2) == 0);
      tick();
      checks++;
      if ({bus.mm_valid, bus.mm_wreg, bus.mm_m2reg, bus.mm_wmem} !== {m_valid, m_wreg, m_m2reg, m_wmem}) begin
        errors++; $display("FAIL rand_ctrl[%0d]: got %b%b%b%b want %b%b%b%b", n,
                           bus.mm_valid, bus.mm_wreg, bus.mm_m2reg, bus.mm_wmem,
                           m_valid, m_wreg, m_m2reg, m_wmem);
      end
      checks++;
      if (bus.mm_r !== m_r || bus.mm_b !== m_b || bus.mm_pc !== m_pc || bus.mm_rn !== m_rn ||
          bus.mm_bd !== m_bd) begin
        errors++; $display("FAIL rand_data[%0d]: got r=%h b=%h pc=%h rn=%0d want r=%h b=%h pc=%h rn=%0d", n,
                           bus.mm_r, bus.mm_b, bus.mm_pc, bus.mm_rn, m_r, m_b, m_pc, m_rn);
      end
      checks++;
      if (bus.exc_req !== m_req || bus.exc_epc !== m_epc || bus.exc_cause !== m_cause ||
          bus.exc_bd !== m_ebd || bus.ex_hold !== (m_pend | m_drain)) begin
        errors++; $display("FAIL rand_exc[%0d]: got req=%b epc=%h cause=%0d bd=%b hold=%b want %b %h %0d %b %b", n,
                           bus.exc_req, bus.exc_epc, bus.exc_cause, bus.exc_bd, bus.ex_hold,
                           m_req, m_epc, m_cause, m_ebd, m_pend | m_drain);
      end
    end
  endtask

  initial begin
    test_reset();
    test_addu();
    test_trap();
    test_delay_slot();
    test_flush_trap();
    test_stall();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
